// File: rtl/pac_pkg.sv
// ---------------------------------------------------------------------------
// pac_pkg -- shared definitions for the PAC table loader.
//
// Holds the loader FSM state type and the table geometry constants used
// by pac_table_loader and its word_assembler sub-module:
//   BYTE_W     width of one stream byte
//   ROM_WORDS  table words loaded per session
//   WORD_BYTES stream bytes per table word
//   ROM_DW     table word width
//   ROM_AW     table address width
// ---------------------------------------------------------------------------
package pac_pkg;

   localparam int BYTE_W     = 8;
   localparam int ROM_WORDS  = 64;
   localparam int WORD_BYTES = 6;
   localparam int ROM_DW     = 48;
   localparam int ROM_AW     = 6;

   // Session phases: waiting, streaming table words, receiving the checksum
   // byte, and reporting the result.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } pac_state_e;

endpackage : pac_pkg

// File: rtl/word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler -- packs an MSB-first byte stream into table words.
//
// Bytes presented with push=1 are shifted into an assembly register. When
// the last byte of a word arrives the completed word is captured into
// word_data and word_pulse goes high for exactly the following cycle.
// word_data holds its value between words.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   clear      discard any partial word (start of a new session)
//   push       accept byte_data this cycle
//   byte_data  stream byte
//   word_last  combinational: this push completes a word
//   word_data  last completed word (first byte in the top byte lane)
//   word_pulse one-cycle strobe, the cycle after a word completes
// ---------------------------------------------------------------------------
module word_assembler #(
   parameter int WORD_BYTES = pac_pkg::WORD_BYTES
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   clear,
   input  logic                                   push,
   input  logic [pac_pkg::BYTE_W-1:0]             byte_data,
   output logic                                   word_last,
   output logic [WORD_BYTES*pac_pkg::BYTE_W-1:0]  word_data,
   output logic                                   word_pulse
);

   import pac_pkg::*;

   localparam int            DW        = WORD_BYTES * BYTE_W;
   localparam int            CW        = $clog2(WORD_BYTES);
   localparam logic [CW-1:0] LAST_BYTE = CW'(WORD_BYTES - 1);

   logic [DW-1:0] shreg;
   logic [DW-1:0] next_word;
   logic [CW-1:0] byte_cnt;

   assign word_last = push && (byte_cnt == LAST_BYTE);

   // Older bytes move toward the MSB, so after a full word the first byte
   // sits in the top lane.
   assign next_word = {shreg[DW-BYTE_W-1:0], byte_data};

   // NOTE: every register here is written with <= so all of them sample the
   // pre-edge values of shreg/byte_cnt; a blocking update would let
   // word_data see an already-shifted shreg.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg      <= '0;
         byte_cnt   <= '0;
         word_data  <= '0;
         word_pulse <= 1'b0;
      end else begin
         word_pulse <= word_last;
         if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
         end else if (push) begin
            shreg    <= next_word;
            byte_cnt <= word_last ? '0 : byte_cnt + CW'(1);
            if (word_last) begin
               word_data <= next_word;
            end
         end
      end
   end

endmodule : word_assembler

// File: rtl/pac_table_loader.sv
// ---------------------------------------------------------------------------
// pac_table_loader -- loads a 64 x 48-bit table from a byte stream.
//
// After start, ROM_WORDS words of WORD_BYTES bytes each are accepted
// (MSB-first), each completed word producing one ROM write strobe. The
// stream ends with one checksum byte which is compared against the XOR of
// all table bytes; the result is reported on err while done=1.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a session (honoured only when idle or done)
//   byte_valid  byte_data is valid
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle
//   wen_trans   ROM write strobe (selects index_wri on the ROM address mux)
//   index_wri   ROM write address
//   D           ROM write data
//   busy        session in progress (loading or awaiting checksum)
//   done        session complete
//   err         checksum mismatch, valid while done=1
// ---------------------------------------------------------------------------
module pac_table_loader #(
   parameter int ROM_WORDS  = pac_pkg::ROM_WORDS,
   parameter int WORD_BYTES = pac_pkg::WORD_BYTES
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic                                   byte_valid,
   input  logic [pac_pkg::BYTE_W-1:0]             byte_data,
   output logic                                   byte_ready,
   output logic                                   wen_trans,
   output logic [pac_pkg::ROM_AW-1:0]             index_wri,
   output logic [WORD_BYTES*pac_pkg::BYTE_W-1:0]  D,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   err
);

   import pac_pkg::*;

   localparam logic [ROM_AW-1:0] LAST_WORD = ROM_AW'(ROM_WORDS - 1);

   pac_state_e          state;
   logic [ROM_AW-1:0]   word_cnt;
   logic [BYTE_W-1:0]   checksum;

   logic                accept;
   logic                session_start;
   logic                asm_push;
   logic                word_last;

   assign accept        = byte_valid && byte_ready;
   assign session_start = start && ((state == IDLE) || (state == DONE));
   assign asm_push      = accept && (state == LOAD);

   word_assembler #(
      .WORD_BYTES (WORD_BYTES)
   ) u_word_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (session_start),
      .push       (asm_push),
      .byte_data  (byte_data),
      .word_last  (word_last),
      .word_data  (D),
      .word_pulse (wen_trans)
   );

   // Control FSM. byte_ready/busy/done/err are registered alongside the
   // state so they change on the same edge as the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         index_wri  <= '0;
         word_cnt   <= '0;
         checksum   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= LOAD;
                  byte_ready <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  word_cnt   <= '0;
                  checksum   <= '0;
               end
            end

            LOAD: begin
               if (accept) begin
                  checksum <= checksum ^ byte_data;
                  if (word_last) begin
                     // Address is captured on the same edge as the word data
                     // inside the assembler, so D and index_wri move together.
                     index_wri <= word_cnt;
                     if (word_cnt == LAST_WORD) begin
                        // byte_ready stays high: the checksum byte may follow
                        // immediately without a bubble.
                        state <= CHECK;
                     end else begin
                        word_cnt <= word_cnt + ROM_AW'(1);
                     end
                  end
               end
            end

            CHECK: begin
               if (accept) begin
                  err        <= (byte_data != checksum);
                  state      <= DONE;
                  byte_ready <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end
            end

            default: begin
               state      <= IDLE;
               byte_ready <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule : pac_table_loader

// File: tb/tb_pac_table_loader.sv
// ---------------------------------------------------------------------------
// tb_pac_table_loader -- self-checking bench for pac_table_loader.
//
// A session-level reference model (count of accepted bytes, list of bytes,
// running XOR) predicts every output each cycle; extra end-of-session
// checks compare strobe counts and known word values against constants.
// ---------------------------------------------------------------------------
module tb_pac_table_loader;

   import pac_pkg::*;

   localparam int TOTAL = ROM_WORDS * WORD_BYTES;   // data bytes per session

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              wen_trans;
   logic [ROM_AW-1:0] index_wri;
   logic [ROM_DW-1:0] D;
   logic              busy;
   logic              done;
   logic              err;

   always #5 clk = ~clk;

   pac_table_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wen_trans  (wen_trans),
      .index_wri  (index_wri),
      .D          (D),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic              m_active;     // session accepting bytes
   logic              m_done;
   logic              m_err;
   logic              m_wen;
   logic [ROM_DW-1:0] m_d;
   logic [ROM_AW-1:0] m_idx;
   int                m_nacc;       // data bytes accepted this session
   logic [7:0]        m_xor;
   logic [7:0]        m_bytes [0:TOTAL-1];
   logic              m_acc;        // a byte was consumed on the last edge

   // per-session observations of the DUT
   int                strobes;
   logic [ROM_DW-1:0] first_d;
   logic [ROM_AW-1:0] first_idx;
   logic [ROM_AW-1:0] last_idx;

   logic [7:0]        src [0:TOTAL];
   logic [7:0]        xor_all;

   // One clock: drive inputs, advance the model on the edge, compare #1 later.
   task automatic cycle(input logic v, input logic [7:0] b, input logic s, input logic r);
      int w;
      byte_valid = v;
      byte_data  = b;
      start      = s;
      reset      = r;
      @(posedge clk);
      m_acc = 1'b0;
      if (r) begin
         m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wen = 1'b0;
         m_d = '0; m_idx = '0; m_nacc = 0; m_xor = '0;
      end else begin
         m_wen = 1'b0;
         if (!m_active) begin
            if (s) begin
               m_active = 1'b1; m_done = 1'b0; m_err = 1'b0;
               m_nacc = 0; m_xor = '0;
            end
         end else if (v) begin
            m_acc = 1'b1;
            if (m_nacc < TOTAL) begin
               m_bytes[m_nacc] = b;
               m_xor = m_xor ^ b;
               if (m_nacc % WORD_BYTES == WORD_BYTES - 1) begin
                  w   = m_nacc / WORD_BYTES;
                  m_d = '0;
                  for (int j = 0; j < WORD_BYTES; j++)
                     m_d = m_d * 256 + ROM_DW'(m_bytes[w * WORD_BYTES + j]);
                  m_idx = ROM_AW'(w);
                  m_wen = 1'b1;
               end
               m_nacc++;
            end else begin
               m_err    = (b != m_xor);
               m_done   = 1'b1;
               m_active = 1'b0;
            end
         end
      end
      #1;
      check("byte_ready", 64'(byte_ready), 64'(m_active));
      check("busy",       64'(busy),       64'(m_active));
      check("done",       64'(done),       64'(m_done));
      check("err",        64'(err),        64'(m_err));
      check("wen_trans",  64'(wen_trans),  64'(m_wen));
      check("index_wri",  64'(index_wri),  64'(m_idx));
      check("D",          64'(D),          64'(m_d));
      if (wen_trans === 1'b1) begin
         if (strobes == 0) begin
            first_d   = D;
            first_idx = index_wri;
         end
         last_idx = index_wri;
         strobes++;
      end
   endtask

   // Start pulse, then stream src[0..TOTAL] with stall_pct% idle cycles.
   // start_at: hold start high while byte start_at is pending (ignored).
   // reset_at: assert reset together with byte reset_at and abort.
   task automatic run_session(input int stall_pct, input logic [7:0] chk_flip,
                              input int start_at, input int reset_at);
      int   p;
      int   cyc;
      logic v;
      logic s;
      logic r;
      src[TOTAL] = xor_all ^ chk_flip;
      strobes = 0;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      p   = 0;
      cyc = 0;
      while (p <= TOTAL && cyc < 5000) begin
         v = ($urandom_range(0, 99) >= stall_pct);
         s = (p == start_at);
         r = (p == reset_at);
         if (r) v = 1'b1;
         cycle(v, src[p], s, r);
         cyc++;
         if (r) break;
         if (m_acc) p++;
      end
      check("session_bound", 64'(cyc < 5000), 64'(1));
      repeat (4) cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      xor_all = '0;
      for (int i = 0; i < TOTAL; i++) begin
         src[i]  = 8'(i % 128);
         xor_all = xor_all ^ src[i];
      end
      m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_wen = 1'b0;
      m_d = '0; m_idx = '0; m_nacc = 0; m_xor = '0; m_acc = 1'b0;
      strobes = 0; first_d = '0; first_idx = '0; last_idx = '0;

      // Reset wins over start and a valid byte in the same cycle.
      cycle(1'b1, 8'hAA, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Gap-free stream, correct checksum.
      run_session(0, 8'h00, -1, -1);
      check("A_strobes",   64'(strobes),   64'd64);
      check("A_word0_D",   64'(first_d),   64'h0000_0001_0203_0405);
      check("A_word0_idx", 64'(first_idx), 64'd0);
      check("A_last_idx",  64'(last_idx),  64'd63);
      check("A_done",      64'(done),      64'd1);
      check("A_err",       64'(err),       64'd0);

      // Restart from DONE, corrupted checksum.
      run_session(0, 8'h01, -1, -1);
      check("B_strobes",   64'(strobes),   64'd64);
      check("B_word0_idx", 64'(first_idx), 64'd0);
      check("B_done",      64'(done),      64'd1);
      check("B_err",       64'(err),       64'd1);

      // Restart clears err; random stalls; start asserted during word 20.
      run_session(40, 8'h00, 20 * WORD_BYTES, -1);
      check("C_strobes",   64'(strobes),   64'd64);
      check("C_word0_D",   64'(first_d),   64'h0000_0001_0203_0405);
      check("C_word0_idx", 64'(first_idx), 64'd0);
      check("C_last_idx",  64'(last_idx),  64'd63);
      check("C_err",       64'(err),       64'd0);

      // Reset on byte 3 of word 11: words 0..10 only.
      run_session(30, 8'h00, -1, 11 * WORD_BYTES + 3);
      check("D_strobes",   64'(strobes),   64'd11);
      check("D_last_idx",  64'(last_idx),  64'd10);
      check("D_busy",      64'(busy),      64'd0);
      check("D_done",      64'(done),      64'd0);

      // Clean session after the abort.
      run_session(20, 8'h00, -1, -1);
      check("E_strobes",   64'(strobes),   64'd64);
      check("E_word0_idx", 64'(first_idx), 64'd0);
      check("E_err",       64'(err),       64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pac_table_loader
